rtc_bus_arbiter: RTL and testbench
==================================

# rtc_bus_arbiter

Shares the RTC's multiplexed address/data parallel bus between three transaction requesters: the initialization sequencer (port 0), the user time-set writer (port 1) and the periodic time/date reader (port 2). Grants one requester at a time, latches its address/data/direction, and generates the full four-phase bus cycle (address strobe, gap, data strobe, recovery) on the RTC pins. Read data is captured and returned to the requester. Sits between the RTC control machines and the top-level tristate pad logic.

## Interface
- PHASE_CYC, 7, cycles each strobe phase (address, data) is held active; legal range 1..31
- GAP_CYC, 7, cycles of each inactive gap (after address, after data); legal range 1..31
- clk_i  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req_i  in  3  per-requester request level; bit 0 = init, 1 = write, 2 = read
- rw_i  in  3  per-requester direction, 1 = read, 0 = write
- addr_i  in  24  packed RTC register addresses, requester k in [8k+7:8k]
- wdata_i  in  24  packed write data, same packing
- gnt_o  out  3  one-hot grant, held for the whole transaction
- done_o  out  3  one-hot single-cycle completion pulse
- rdata_o  out  8  last read data captured
- busy_o  out  1  high whenever state is not IDLE
- ad_o  out  8  address/data value toward pads
- ad_oe_o  out  1  pad output enable for ad_o
- ad_i  in  8  bus value from pads
- a_d_o  out  1  0 = address phase, 1 = data phase
- rd_n_o, wr_n_o, cs_n_o  out  1 each  active-low RTC strobes

## Operation
- States: IDLE, ADDR, GAP1, DATA, RECOV; 5-bit phase counter.
- IDLE: if any req_i bit set, arbitrate, latch addr/wdata/rw of winner, set gnt_o, go ADDR with counter cleared.
- ADDR (PHASE_CYC cycles): ad_o = latched addr, ad_oe_o=1, a_d_o=0, cs_n_o=0, wr_n_o=0, rd_n_o=1.
- GAP1 (GAP_CYC): cs_n_o=wr_n_o=rd_n_o=1, ad_o/a_d_o held.
- DATA (PHASE_CYC): a_d_o=1, cs_n_o=0. Write: ad_o = latched wdata, ad_oe_o=1, wr_n_o=0. Read: ad_oe_o=0, rd_n_o=0; ad_i sampled into rdata_o on the last DATA cycle.
- RECOV (GAP_CYC): all strobes high, ad_oe_o=0; done_o[winner] pulses on last RECOV cycle; next state IDLE, gnt_o cleared.
- Arbitration: fixed priority 0 > 1 > 2 (see Configuration).
- Operands are latched at grant; changing inputs afterward has no effect. req_i still high in IDLE after done_o is a new transaction.
- Dropping req_i mid-transaction does not abort it.

## Timing
- Reset values: state IDLE, gnt_o=0, done_o=0, rdata_o=8'h00, busy_o=0, ad_o=8'h00, ad_oe_o=0, a_d_o=0, rd_n_o=wr_n_o=cs_n_o=1, RR pointer 0.
- req_i seen in IDLE at edge N -> gnt_o and ADDR outputs valid after edge N.
- Transaction length from first gnt_o cycle to done_o inclusive: 2*PHASE_CYC + 2*GAP_CYC (28 at defaults).
- Minimum one IDLE cycle between back-to-back transactions.
- Reset asserted mid-transaction: all outputs to reset values on that edge; no done_o; rdata_o cleared.
- Simultaneous requests resolved in the IDLE cycle only; later arrivals wait.

## Configuration
- RTC_ARB_RR_EN defined: round-robin; search starts at requester after last granted (pointer updated at grant; after reset starts at 0).
- Undefined: fixed priority 0 > 1 > 2; pointer logic absent.

## Structure
- Shared package rtc_pkg: state enum, requester index constants (REQ_INIT=0, REQ_WR=1, REQ_RD=2), RTC register address constants.
- One sub-module: rtc_arb_pick (combinational one-hot winner from req vector and pointer), reused by other bus owners.

## Test plan
- Single write: req_i=3'b001, addr 8'h02, data 8'h10 -> gnt_o=001, 7 cycles ad_o=02/a_d_o=0/wr_n_o=0, 7 idle, 7 cycles ad_o=10/a_d_o=1/wr_n_o=0, done_o=001 at cycle 28.
- Read: req_i=3'b100, addr 8'h21, ad_i=8'h45 -> ad_oe_o=0 and rd_n_o=0 in DATA, rdata_o=45 with done_o=100.
- Contention: req_i=3'b111 held -> fixed: order 0,0,0...; with RTC_ARB_RR_EN: grants 0,1,2,0.
- Back-to-back: req 1 held high -> exactly one IDLE cycle between done_o and next gnt_o.
- Reset low during DATA -> next edge all strobes high, gnt_o=0, no done_o, rdata_o=0.
- PHASE_CYC=1, GAP_CYC=1 -> done_o four cycles after grant start, strobes one cycle each.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC bus types, requester indices and register addresses
package rtc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP1,
    S_DATA,
    S_RECOV
  } rtc_state_e;

  localparam int N_REQ    = 3;
  localparam int REQ_INIT = 0;
  localparam int REQ_WR   = 1;
  localparam int REQ_RD   = 2;

  localparam logic [7:0] RTC_REG_SEC    = 8'h00;
  localparam logic [7:0] RTC_REG_MIN    = 8'h02;
  localparam logic [7:0] RTC_REG_HOUR   = 8'h04;
  localparam logic [7:0] RTC_REG_DAY    = 8'h07;
  localparam logic [7:0] RTC_REG_MONTH  = 8'h08;
  localparam logic [7:0] RTC_REG_YEAR   = 8'h09;
  localparam logic [7:0] RTC_REG_CTRL_A = 8'h0A;
  localparam logic [7:0] RTC_REG_CTRL_B = 8'h0B;

  // Round-robin search restarts at the requester after the one just granted.
  function automatic logic [1:0] next_ptr(input logic [2:0] onehot);
    logic [1:0] p;
    p = 2'd0;
    if (onehot[0]) p = 2'd1;
    if (onehot[1]) p = 2'd2;
    if (onehot[2]) p = 2'd0;
    return p;
  endfunction

endpackage

// File: rtl/rtc_arb_pick.sv
// rtl/rtc_arb_pick.sv - combinational one-hot winner of three requesters, search starting at ptr
module rtc_arb_pick (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  logic [2:0] rot;
  logic [2:0] pick;

  // Rotate so the pointed-to requester lands in bit 0, pick lowest, rotate back.
  always_comb begin
    rot = req;
    case (ptr)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase

    pick = 3'b000;
    if (rot[0])      pick = 3'b001;
    else if (rot[1]) pick = 3'b010;
    else if (rot[2]) pick = 3'b100;

    gnt = pick;
    case (ptr)
      2'd1:    gnt = {pick[1], pick[0], pick[2]};
      2'd2:    gnt = {pick[0], pick[2], pick[1]};
      default: gnt = pick;
    endcase
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - three-port RTC parallel bus arbiter and cycle generator; RTC_ARB_RR_EN selects round-robin
module rtc_bus_arbiter
  import rtc_pkg::*;
#(
  parameter int PHASE_CYC = 7,
  parameter int GAP_CYC   = 7
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic [2:0]  req_i,
  input  logic [2:0]  rw_i,
  input  logic [23:0] addr_i,
  input  logic [23:0] wdata_i,
  output logic [2:0]  gnt_o,
  output logic [2:0]  done_o,
  output logic [7:0]  rdata_o,
  output logic        busy_o,
  output logic [7:0]  ad_o,
  output logic        ad_oe_o,
  input  logic [7:0]  ad_i,
  output logic        a_d_o,
  output logic        rd_n_o,
  output logic        wr_n_o,
  output logic        cs_n_o
);

  localparam logic [4:0] PH_LAST  = 5'(PHASE_CYC - 1);
  localparam logic [4:0] GAP_LAST = 5'(GAP_CYC - 1);

  rtc_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] win_q;
  logic       rw_q;
  logic [7:0] addr_q, wdata_q, rdata_q;
  logic [2:0] pick;
  logic [1:0] ptr;
  logic [7:0] sel_addr, sel_wdata;
  logic       sel_rw;
  logic       grant;

`ifdef RTC_ARB_RR_EN
  logic [1:0] ptr_q;
  assign ptr = ptr_q;

  always_ff @(posedge clk_i) begin
    if (!reset) begin
      ptr_q <= 2'd0;
    end else if (grant) begin
      ptr_q <= next_ptr(pick);
    end
  end
`else
  assign ptr = 2'd0;
`endif

  rtc_arb_pick u_pick (
    .req (req_i),
    .ptr (ptr),
    .gnt (pick)
  );

  assign grant = (state_q == S_IDLE) && (|req_i);

  always_comb begin
    sel_addr  = addr_i[7:0];
    sel_wdata = wdata_i[7:0];
    sel_rw    = rw_i[REQ_INIT];
    if (pick[REQ_WR]) begin
      sel_addr  = addr_i[15:8];
      sel_wdata = wdata_i[15:8];
      sel_rw    = rw_i[REQ_WR];
    end
    if (pick[REQ_RD]) begin
      sel_addr  = addr_i[23:16];
      sel_wdata = wdata_i[23:16];
      sel_rw    = rw_i[REQ_RD];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = 5'd0;
        if (|req_i) state_d = S_ADDR;
      end
      S_ADDR: if (cnt_q == PH_LAST) begin
        state_d = S_GAP1;
        cnt_d   = 5'd0;
      end
      S_GAP1: if (cnt_q == GAP_LAST) begin
        state_d = S_DATA;
        cnt_d   = 5'd0;
      end
      S_DATA: if (cnt_q == PH_LAST) begin
        state_d = S_RECOV;
        cnt_d   = 5'd0;
      end
      S_RECOV: if (cnt_q == GAP_LAST) begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      win_q   <= 3'b000;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        win_q   <= pick;
        rw_q    <= sel_rw;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state_q == S_DATA && cnt_q == PH_LAST && rw_q) rdata_q <= ad_i;
    end
  end

  // Pin outputs decode straight from state so a reset edge returns them to idle levels at once.
  always_comb begin
    ad_o    = 8'h00;
    ad_oe_o = 1'b0;
    a_d_o   = 1'b0;
    rd_n_o  = 1'b1;
    wr_n_o  = 1'b1;
    cs_n_o  = 1'b1;
    done_o  = 3'b000;
    case (state_q)
      S_ADDR: begin
        ad_o    = addr_q;
        ad_oe_o = 1'b1;
        cs_n_o  = 1'b0;
        wr_n_o  = 1'b0;
      end
      S_GAP1: begin
        ad_o    = addr_q;
        ad_oe_o = 1'b1;
      end
      S_DATA: begin
        a_d_o  = 1'b1;
        cs_n_o = 1'b0;
        if (rw_q) begin
          rd_n_o = 1'b0;
        end else begin
          ad_o    = wdata_q;
          ad_oe_o = 1'b1;
          wr_n_o  = 1'b0;
        end
      end
      S_RECOV: begin
        a_d_o = 1'b1;
        ad_o  = rw_q ? 8'h00 : wdata_q;
        if (cnt_q == GAP_LAST) done_o = win_q;
      end
      default: ;
    endcase
  end

  assign gnt_o   = (state_q != S_IDLE) ? win_q : 3'b000;
  assign busy_o  = (state_q != S_IDLE);
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb/tb_rtc_bus_arbiter.sv - self-checking bench for rtc_bus_arbiter at default and minimum timing
module tb_rtc_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_a, req_b, rw;
  logic [23:0] addr, wdata;
  logic [7:0]  ad_in;

  logic [2:0] gnt_w [2];
  logic [2:0] done_w [2];
  logic [7:0] rdata_w [2];
  logic [7:0] ad_w [2];
  logic       busy_w [2], oe_w [2], adsel_w [2], rdn_w [2], wrn_w [2], csn_w [2];

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m [2];
  logic [7:0] rdata_m [2];

  always #5 clk = ~clk;

  rtc_bus_arbiter dut0 (
    .clk_i(clk), .reset(reset), .req_i(req_a), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_w[0]), .done_o(done_w[0]), .rdata_o(rdata_w[0]), .busy_o(busy_w[0]),
    .ad_o(ad_w[0]), .ad_oe_o(oe_w[0]), .ad_i(ad_in), .a_d_o(adsel_w[0]),
    .rd_n_o(rdn_w[0]), .wr_n_o(wrn_w[0]), .cs_n_o(csn_w[0])
  );

  rtc_bus_arbiter #(.PHASE_CYC(1), .GAP_CYC(1)) dut1 (
    .clk_i(clk), .reset(reset), .req_i(req_b), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_w[1]), .done_o(done_w[1]), .rdata_o(rdata_w[1]), .busy_o(busy_w[1]),
    .ad_o(ad_w[1]), .ad_oe_o(oe_w[1]), .ad_i(ad_in), .a_d_o(adsel_w[1]),
    .rd_n_o(rdn_w[1]), .wr_n_o(wrn_w[1]), .cs_n_o(csn_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_win(input logic [2:0] r, input int p);
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (p + i) % 3;
      if (r[k]) return 3'(1 << k);
    end
    return 3'b000;
  endfunction

  task automatic check_reset(input int d);
    chk("rst_gnt",   32'(gnt_w[d]),   32'h0);
    chk("rst_done",  32'(done_w[d]),  32'h0);
    chk("rst_busy",  32'(busy_w[d]),  32'h0);
    chk("rst_rdata", 32'(rdata_w[d]), 32'h0);
    chk("rst_ad",    32'(ad_w[d]),    32'h0);
    chk("rst_oe",    32'(oe_w[d]),    32'h0);
    chk("rst_a_d",   32'(adsel_w[d]), 32'h0);
    chk("rst_strb",  32'({rdn_w[d], wrn_w[d], csn_w[d]}), 32'h7);
  endtask

  // Starts at a negedge with DUT d idle; ends at a negedge with DUT d idle again.
  task automatic run_txn(input int d, input logic [2:0] r, input logic [2:0] rwv,
                         input logic [23:0] a, input logic [23:0] w, input logic [7:0] x,
                         input bit keep);
    int P, G, L, k;
    logic [2:0] win;
    logic rd, ia, ig, id, ir;
    logic [7:0] ea, ew;
    P = (d != 0) ? 1 : 7;
    G = (d != 0) ? 1 : 7;
    L = 2 * P + 2 * G;
`ifdef RTC_ARB_RR_EN
    win = model_win(r, ptr_m[d]);
`else
    win = model_win(r, 0);
`endif
    k = win[0] ? 0 : (win[1] ? 1 : 2);
    rd = rwv[k];
    ea = a[8*k +: 8];
    ew = w[8*k +: 8];
    if (d == 0) req_a = r; else req_b = r;
    rw = rwv; addr = a; wdata = w; ad_in = x;
    @(posedge clk);
    ptr_m[d] = (k + 1) % 3;
    for (int t = 0; t < L; t++) begin
      @(negedge clk);
      if (t == 0) begin
        rw = 3'($urandom); addr = 24'($urandom); wdata = 24'($urandom);
        if (!keep) begin
          if (d == 0) req_a = 3'b000; else req_b = 3'b000;
        end
      end
      ia = (t < P);
      ig = (t >= P) && (t < P + G);
      id = (t >= P + G) && (t < 2 * P + G);
      ir = (t >= 2 * P + G);
      chk("gnt",  32'(gnt_w[d]),  32'(win));
      chk("busy", 32'(busy_w[d]), 32'h1);
      chk("done", 32'(done_w[d]), (t == L - 1) ? 32'(win) : 32'h0);
      chk("cs_n", 32'(csn_w[d]),  32'(!(ia || id)));
      chk("wr_n", 32'(wrn_w[d]),  32'(!(ia || (id && !rd))));
      chk("rd_n", 32'(rdn_w[d]),  32'(!(id && rd)));
      if (!ig) chk("ad_oe", 32'(oe_w[d]), 32'(ia || (id && !rd)));
      if (!ir) chk("a_d", 32'(adsel_w[d]), 32'(id));
      if (ia || ig) chk("ad_addr", 32'(ad_w[d]), 32'(ea));
      else if (id && !rd) chk("ad_wdata", 32'(ad_w[d]), 32'(ew));
      chk("rdata", 32'(rdata_w[d]), (ir && rd) ? 32'(x) : 32'(rdata_m[d]));
      @(posedge clk);
    end
    if (rd) rdata_m[d] = x;
    @(negedge clk);
    chk("idle_gnt",  32'(gnt_w[d]),  32'h0);
    chk("idle_busy", 32'(busy_w[d]), 32'h0);
    chk("idle_done", 32'(done_w[d]), 32'h0);
    chk("idle_cs_n", 32'(csn_w[d]),  32'h1);
  endtask

  initial begin
    reset = 1'b0;
    req_a = 3'b000; req_b = 3'b000; rw = 3'b000;
    addr = 24'h0; wdata = 24'h0; ad_in = 8'h00;
    ptr_m[0] = 0; ptr_m[1] = 0;
    rdata_m[0] = 8'h00; rdata_m[1] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    reset = 1'b1;

    run_txn(0, 3'b001, 3'b000, 24'h000002, 24'h000010, 8'h00, 1'b0);
    run_txn(0, 3'b100, 3'b100, 24'h210000, 24'h000000, 8'h45, 1'b0);

    run_txn(0, 3'b111, 3'b000, 24'h0B0A09, 24'h332211, 8'h00, 1'b1);
    run_txn(0, 3'b111, 3'b010, 24'h0B0A09, 24'h665544, 8'h5A, 1'b1);
    run_txn(0, 3'b111, 3'b100, 24'h0B0A09, 24'h998877, 8'hC3, 1'b0);

    run_txn(0, 3'b010, 3'b000, 24'h000400, 24'h001200, 8'h00, 1'b1);
    run_txn(0, 3'b010, 3'b000, 24'h000700, 24'h003400, 8'h00, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_txn(0, 3'($urandom_range(1, 7)), 3'($urandom), 24'($urandom), 24'($urandom),
              8'($urandom), (i != 11) && ($urandom_range(0, 1) == 1));
    end

    run_txn(1, 3'b010, 3'b000, 24'h000800, 24'h00AB00, 8'h00, 1'b1);
    run_txn(1, 3'b110, 3'b110, 24'h090800, 24'h000000, 8'hA5, 1'b0);
    run_txn(1, 3'b001, 3'b000, 24'h00000A, 24'h0000CD, 8'h00, 1'b0);

    run_txn(0, 3'b100, 3'b100, 24'h090000, 24'h000000, 8'h7E, 1'b0);
    req_a = 3'b001; rw = 3'b000; addr = 24'h000009; wdata = 24'h000055;
    @(posedge clk);
    repeat (7 + 7 + 2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_cs_n", 32'(csn_w[0]), 32'h0);
    reset = 1'b0;
    req_a = 3'b000;
    @(posedge clk);
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    rdata_m[0] = 8'h00; rdata_m[1] = 8'h00;
    ptr_m[0] = 0; ptr_m[1] = 0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", 32'(busy_w[0]), 32'h0);

    run_txn(0, 3'b111, 3'b000, 24'h030201, 24'h0C0B0A, 8'h00, 1'b0);
    run_txn(0, 3'b110, 3'b010, 24'h030201, 24'h0C0B0A, 8'h96, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
